decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DW, default 32: datapath width; SHALL be >= 32.
REQ-002 Parameter NREG, default 32: register count, power of two; AW = log2(NREG).
REQ-003 Parameter ZERO_R0, default 1: 1 = register 0 reads as zero and ignores writes.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 if_valid  in  1  IF/ID holds a valid instruction.
REQ-007 if_pc  in  DW  PC of the IF/ID instruction; if_ir  in  32  instruction word.
REQ-008 wb_we  in  1  write-back enable; wb_rd  in  AW  destination; wb_data  in  DW  write data.
REQ-009 flush  in  1  taken branch or jump resolved downstream; kill the instruction in decode.
REQ-010 stall  out  1  combinational; holds IF and IF/ID when 1.
REQ-011 illegal  out  1  registered one-cycle pulse for an unsupported opcode or funct.
REQ-012 dx_valid, dx_memtoreg, dx_regwrite, dx_memread, dx_memwrite, dx_branch, dx_jump  out  1 each  ID/EX controls.
REQ-013 dx_aluctr  out  3  ALU op: add=0, sub=1, slt=2, and=3, beq=5, bne=6, or=7.
REQ-014 dx_pc, dx_a, dx_b, dx_md, dx_imm, dx_jt  out  DW each  ID/EX operands.
REQ-015 dx_rs, dx_rt, dx_rd  out  AW each  register indices, used for downstream forwarding.

Function
REQ-016 The block SHALL decode R-type (funct 32/34/36/37/42), lw 35, sw 43, addi 8, andi 12, ori 13, slti 10, beq 4, bne 5 and j 2.
REQ-017 dx_imm SHALL be sign-extended IR[15:0], except andi and ori, which SHALL zero-extend.
REQ-018 For R-type, dx_b SHALL be rt data and dx_rd = IR[15:11].
REQ-019 For I-type ALU ops and lw, dx_b SHALL be dx_imm and dx_rd = IR[20:16].
REQ-020 For sw, dx_b SHALL be dx_imm, dx_md SHALL be rt data, and regwrite SHALL be 0.
REQ-021 For beq and bne, dx_b SHALL be rt data, dx_branch = 1, and no register or memory write occurs.
REQ-022 For j, dx_jump SHALL be 1 and dx_jt = {if_pc[31:28], IR[25:0], 2'b00}, zero-extended to DW.
REQ-023 The register file SHALL be written on the clock edge when wb_we = 1, except for wb_rd = 0 when ZERO_R0 = 1.
REQ-024 Read bypass: when wb_we = 1 and wb_rd equals the rs or rt being read, that read SHALL return wb_data in the same cycle (register 0 excepted).
REQ-025 Load-use: stall SHALL be 1 when all of the following hold:
- if_valid, dx_valid and dx_memread are all 1;
- dx_rd != 0;
- dx_rd equals rs, or equals rt for R-type, sw, beq or bne.
REQ-026 While stall = 1, the block SHALL load a bubble into ID/EX: dx_valid, regwrite, memread, memwrite, branch and jump = 0.
REQ-027 A stall SHALL last exactly one cycle per load-use pair.
REQ-028 flush SHALL take priority over stall and decode: next edge loads a bubble, and stall SHALL be forced to 0.
REQ-029 if_valid = 0 SHALL load a bubble.
REQ-030 An illegal instruction SHALL load a bubble and pulse illegal for one cycle, unless flush = 1.
REQ-031 Latency SHALL be one cycle from IF/ID to ID/EX, and dx_pc SHALL equal if_pc.
REQ-032 Bubbles SHALL leave data outputs unspecified but all control outputs 0.

Reset
REQ-033 While rst = 1, all dx_* outputs and illegal SHALL be 0, and stall SHALL be 0.
REQ-034 Register file contents SHALL be cleared to 0 on reset.
REQ-035 An instruction in decode when rst asserts SHALL be discarded; the first post-reset edge with if_valid decodes normally.

Verification
REQ-036 Write r5 = 0x0000_1234 via wb, then add r3,r5,r0 -> dx_a = 0x1234, dx_aluctr = 0, dx_rd = 3, dx_regwrite = 1.
REQ-037 wb writes r7 = 0xDEAD_BEEF in the same cycle as decoding sub r1,r7,r7 -> dx_a = dx_b = 0xDEADBEEF (bypass).
REQ-038 lw r2,4(r0) then add r4,r2,r1 -> stall = 1 for exactly one cycle; bubble in ID/EX; add issues the next cycle.
REQ-039 andi r1,r0,0x8000 and addi r1,r0,0x8000 -> dx_imm = 0x0000_8000 and 0xFFFF_8000 respectively.
REQ-040 Raise flush during a load-use stall -> stall = 0 and a bubble is loaded.
REQ-041 Opcode 63 -> illegal pulses once and dx_valid = 0; rst mid-stream -> all outputs 0 and r0..r31 read 0.

Source files
------------

// File: rtl/decode_if.sv
`default_nettype none
// ============================================================================
//  Module   : decode_if
//  Purpose  : IF/ID, write-back and ID/EX signal bundle for the decode stage.
//  Revision : 1.0
// ============================================================================
interface decode_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          if_valid;
    logic [DW-1:0] if_pc;
    logic [31:0]   if_ir;
    logic          wb_we;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          flush;
    logic          stall;
    logic          illegal;
    logic          dx_valid;
    logic          dx_memtoreg;
    logic          dx_regwrite;
    logic          dx_memread;
    logic          dx_memwrite;
    logic          dx_branch;
    logic          dx_jump;
    logic [2:0]    dx_aluctr;
    logic [DW-1:0] dx_pc;
    logic [DW-1:0] dx_a;
    logic [DW-1:0] dx_b;
    logic [DW-1:0] dx_md;
    logic [DW-1:0] dx_imm;
    logic [DW-1:0] dx_jt;
    logic [AW-1:0] dx_rs;
    logic [AW-1:0] dx_rt;
    logic [AW-1:0] dx_rd;

    modport master (
        output if_valid, if_pc, if_ir, wb_we, wb_rd, wb_data, flush,
        input  stall, illegal, dx_valid, dx_memtoreg, dx_regwrite, dx_memread,
               dx_memwrite, dx_branch, dx_jump, dx_aluctr, dx_pc, dx_a, dx_b,
               dx_md, dx_imm, dx_jt, dx_rs, dx_rt, dx_rd
    );

    modport slave (
        input  if_valid, if_pc, if_ir, wb_we, wb_rd, wb_data, flush,
        output stall, illegal, dx_valid, dx_memtoreg, dx_regwrite, dx_memread,
               dx_memwrite, dx_branch, dx_jump, dx_aluctr, dx_pc, dx_a, dx_b,
               dx_md, dx_imm, dx_jt, dx_rs, dx_rt, dx_rd
    );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage
//  Purpose  : Instruction decode, register file with write bypass, load-use
//             stall and ID/EX pipeline register.
//  Revision : 1.0
// ============================================================================
module decode_stage #(
    parameter int DW      = 32,
    parameter int NREG    = 32,
    parameter int ZERO_R0 = 1
) (
    input  wire logic clk,
    input  wire logic rst,
    decode_if.slave   bus
);
    localparam int AW = $clog2(NREG);

    localparam logic [5:0] c_OP_RTYPE = 6'd0;
    localparam logic [5:0] c_OP_J     = 6'd2;
    localparam logic [5:0] c_OP_BEQ   = 6'd4;
    localparam logic [5:0] c_OP_BNE   = 6'd5;
    localparam logic [5:0] c_OP_ADDI  = 6'd8;
    localparam logic [5:0] c_OP_SLTI  = 6'd10;
    localparam logic [5:0] c_OP_ANDI  = 6'd12;
    localparam logic [5:0] c_OP_ORI   = 6'd13;
    localparam logic [5:0] c_OP_LW    = 6'd35;
    localparam logic [5:0] c_OP_SW    = 6'd43;

    logic [DW-1:0] r_rf [NREG];

    logic [5:0]    w_op;
    logic [5:0]    w_funct;
    logic [AW-1:0] w_rs, w_rt, w_rdf;
    logic [DW-1:0] w_rs_data, w_rt_data, w_imm, w_jt;
    logic          w_legal, w_regwrite, w_memread, w_memwrite, w_branch, w_jump;
    logic          w_b_imm, w_rd_is_rdf, w_zext, w_uses_rt, w_hazard, w_issue;
    logic [2:0]    w_alu;

    assign w_op    = bus.if_ir[31:26];
    assign w_funct = bus.if_ir[5:0];
    assign w_rs    = AW'(bus.if_ir[25:21]);
    assign w_rt    = AW'(bus.if_ir[20:16]);
    assign w_rdf   = AW'(bus.if_ir[15:11]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
        end else if (bus.wb_we && !(ZERO_R0 != 0 && bus.wb_rd == '0)) begin
            r_rf[bus.wb_rd] <= bus.wb_data;
        end
    end

    // A same-cycle write-back wins over the stored value.
    always_comb begin
        w_rs_data = r_rf[w_rs];
        w_rt_data = r_rf[w_rt];
        if (bus.wb_we && bus.wb_rd == w_rs) w_rs_data = bus.wb_data;
        if (bus.wb_we && bus.wb_rd == w_rt) w_rt_data = bus.wb_data;
        if (ZERO_R0 != 0 && w_rs == '0) w_rs_data = '0;
        if (ZERO_R0 != 0 && w_rt == '0) w_rt_data = '0;
    end

    always_comb begin
        w_legal     = 1'b1;
        w_regwrite  = 1'b0;
        w_memread   = 1'b0;
        w_memwrite  = 1'b0;
        w_branch    = 1'b0;
        w_jump      = 1'b0;
        w_b_imm     = 1'b0;
        w_rd_is_rdf = 1'b0;
        w_zext      = 1'b0;
        w_uses_rt   = 1'b0;
        w_alu       = 3'd0;
        case (w_op)
            c_OP_RTYPE: begin
                w_uses_rt   = 1'b1;
                w_rd_is_rdf = 1'b1;
                w_regwrite  = 1'b1;
                case (w_funct)
                    6'd32:   w_alu = 3'd0;
                    6'd34:   w_alu = 3'd1;
                    6'd36:   w_alu = 3'd3;
                    6'd37:   w_alu = 3'd7;
                    6'd42:   w_alu = 3'd2;
                    default: w_legal = 1'b0;
                endcase
            end
            c_OP_LW:   begin w_memread = 1'b1; w_regwrite = 1'b1; w_b_imm = 1'b1; end
            c_OP_SW:   begin w_memwrite = 1'b1; w_b_imm = 1'b1; w_uses_rt = 1'b1; end
            c_OP_ADDI: begin w_regwrite = 1'b1; w_b_imm = 1'b1; end
            c_OP_ANDI: begin w_regwrite = 1'b1; w_b_imm = 1'b1; w_zext = 1'b1; w_alu = 3'd3; end
            c_OP_ORI:  begin w_regwrite = 1'b1; w_b_imm = 1'b1; w_zext = 1'b1; w_alu = 3'd7; end
            c_OP_SLTI: begin w_regwrite = 1'b1; w_b_imm = 1'b1; w_alu = 3'd2; end
            c_OP_BEQ:  begin w_branch = 1'b1; w_uses_rt = 1'b1; w_alu = 3'd5; end
            c_OP_BNE:  begin w_branch = 1'b1; w_uses_rt = 1'b1; w_alu = 3'd6; end
            c_OP_J:    w_jump = 1'b1;
            default:   w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_imm = w_zext ? {{(DW-16){1'b0}}, bus.if_ir[15:0]}
                       : {{(DW-16){bus.if_ir[15]}}, bus.if_ir[15:0]};
        w_jt        = '0;
        w_jt[31:0]  = {bus.if_pc[31:28], bus.if_ir[25:0], 2'b00};
    end

    // The bubble inserted on a stall clears dx_valid, so a stall cannot repeat.
    assign w_hazard  = bus.dx_valid && bus.dx_memread && (bus.dx_rd != '0) &&
                       ((bus.dx_rd == w_rs) || (w_uses_rt && bus.dx_rd == w_rt));
    assign bus.stall = bus.if_valid && !bus.flush && w_hazard;
    assign w_issue   = bus.if_valid && !bus.flush && !bus.stall && w_legal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.illegal     <= 1'b0;
            bus.dx_valid    <= 1'b0;
            bus.dx_memtoreg <= 1'b0;
            bus.dx_regwrite <= 1'b0;
            bus.dx_memread  <= 1'b0;
            bus.dx_memwrite <= 1'b0;
            bus.dx_branch   <= 1'b0;
            bus.dx_jump     <= 1'b0;
            bus.dx_aluctr   <= 3'd0;
            bus.dx_pc       <= '0;
            bus.dx_a        <= '0;
            bus.dx_b        <= '0;
            bus.dx_md       <= '0;
            bus.dx_imm      <= '0;
            bus.dx_jt       <= '0;
            bus.dx_rs       <= '0;
            bus.dx_rt       <= '0;
            bus.dx_rd       <= '0;
        end else begin
            bus.illegal     <= bus.if_valid && !bus.flush && !bus.stall && !w_legal;
            bus.dx_valid    <= w_issue;
            bus.dx_memtoreg <= w_issue && w_memread;
            bus.dx_regwrite <= w_issue && w_regwrite;
            bus.dx_memread  <= w_issue && w_memread;
            bus.dx_memwrite <= w_issue && w_memwrite;
            bus.dx_branch   <= w_issue && w_branch;
            bus.dx_jump     <= w_issue && w_jump;
            bus.dx_aluctr   <= w_issue ? w_alu : 3'd0;
            bus.dx_pc       <= bus.if_pc;
            bus.dx_a        <= w_rs_data;
            bus.dx_b        <= w_b_imm ? w_imm : w_rt_data;
            bus.dx_md       <= w_rt_data;
            bus.dx_imm      <= w_imm;
            bus.dx_jt       <= w_jt;
            bus.dx_rs       <= w_rs;
            bus.dx_rt       <= w_rt;
            bus.dx_rd       <= w_rd_is_rdf ? w_rdf : w_rt;
        end
    end
endmodule
`default_nettype wire
